// File: rtl/logic_gate_unit.sv
// logic_gate_unit: registered WIDTH-bit bitwise logic unit, eight ops,
// valid/ready on both sides, result flags and saturating all-ones counter.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (op_a, op_b, op_sel)
//   out_valid/out_ready result handshake (result, all_ones, any_one)
//   match_cnt, clr_cnt  saturating count of consumed all-ones results
//   pop_cnt             ones count of result (only with LGU_POPCOUNT_EN)
//
// Build option: define LGU_POPCOUNT_EN to add the pop_cnt port and logic.
module logic_gate_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       op_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             all_ones,
    output logic             any_one,
    output logic [CNT_W-1:0] match_cnt,
    input  logic             clr_cnt
`ifdef LGU_POPCOUNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] pop_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             all_q;
    logic             any_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;
    logic             consume;

    // Single-entry output stage: a slot frees up in the same cycle
    // the downstream takes the held result.
    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_comb begin
        res_d = '0;
        unique case (op_sel)
            3'b000: res_d = op_a & op_b;
            3'b001: res_d = op_a | op_b;
            3'b010: res_d = op_a ^ op_b;
            3'b011: res_d = ~(op_a & op_b);
            3'b100: res_d = ~(op_a | op_b);
            3'b101: res_d = ~(op_a ^ op_b);
            3'b110: res_d = op_a;
            3'b111: res_d = ~op_a;
        endcase
    end

    // Clear wins over a coincident increment; count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (consume && all_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

`ifdef LGU_POPCOUNT_EN
    logic [$clog2(WIDTH+1)-1:0] pc_q;
    logic [$clog2(WIDTH+1)-1:0] pc_d;

    always_comb begin
        pc_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc_d = pc_d + {{($clog2(WIDTH+1)-1){1'b0}}, res_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else if (accept) begin
            pc_q <= pc_d;
        end
    end

    assign pop_cnt = pc_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            res_q   <= '0;
            all_q   <= 1'b0;
            any_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                res_q <= res_d;
                all_q <= &res_d;
                any_q <= |res_d;
            end
            case (state_q)
                EMPTY: if (accept) state_q <= FULL;
                FULL:  if (consume && !accept) state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign result    = res_q;
    assign all_ones  = all_q;
    assign any_one   = any_q;
    assign match_cnt = cnt_q;

endmodule
